// File: rtl/toggle_enable_gen_pkg.sv
//============================================================================
// Module : toggle_pkg
// Desc   : Shared edge-select codes and debounce FSM encoding for the
//          toggle enable generator and its neighbours.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package toggle_pkg;

   // Edge-select codes presented on the mode input.
   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;
   localparam logic [1:0] MODE_NONE = 2'b11;

   // CHECK_* states hold a candidate level that has not yet survived the
   // full debounce window.
   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      CHECK_HI  = 2'b01,
      STABLE_HI = 2'b10,
      CHECK_LO  = 2'b11
   } state_t;

endpackage : toggle_pkg

`default_nettype wire

// File: rtl/toggle_enable_gen_if.sv
//============================================================================
// Module : toggle_enable_gen_if
// Desc   : Level-in / enable-out bundle between a stimulus source and the
//          toggle enable generator.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface toggle_enable_gen_if #(
   parameter int PCOUNT_W = 8
);

   logic                raw_in;
   logic [1:0]          mode;
   logic                bit_out;
   logic                stable_level;
   logic [PCOUNT_W-1:0] pulse_count;

   // Source side: owns the raw level and edge selection.
   modport master (
      output raw_in,
      output mode,
      input  bit_out,
      input  stable_level,
      input  pulse_count
   );

   // Generator side.
   modport slave (
      input  raw_in,
      input  mode,
      output bit_out,
      output stable_level,
      output pulse_count
   );

endinterface : toggle_enable_gen_if

`default_nettype wire

// File: rtl/toggle_enable_gen_sync_chain.sv
//============================================================================
// Module : sync_chain
// Desc   : Multi-flop synchronizer for a single asynchronous level, with
//          asynchronous active-high clear.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_chain;

   // Each stage is an individual flop so tools can tag the chain for
   // metastability-aware placement.
   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge clr) begin
               if (clr) begin
                  r_chain[gi] <= 1'b0;
               end else begin
                  r_chain[gi] <= d;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge clr) begin
               if (clr) begin
                  r_chain[gi] <= 1'b0;
               end else begin
                  r_chain[gi] <= r_chain[gi-1];
               end
            end
         end
      end
   endgenerate

   assign q = r_chain[STAGES-1];

endmodule : sync_chain

`default_nettype wire

// File: rtl/toggle_enable_gen.sv
//============================================================================
// Module : toggle_enable_gen
// Desc   : Synchronizes and debounces a raw level, then issues a one-cycle
//          enable on the selected qualified edge and counts issued pulses.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module toggle_enable_gen
   import toggle_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3,
   parameter int PCOUNT_W        = 8
) (
   input  logic               clk,
   input  logic               clr,
   toggle_enable_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_stable;
   logic                r_bit;
   logic [PCOUNT_W-1:0] r_pcount;

   logic                w_s;
   logic                w_fast;
   logic                w_acc_rise;
   logic                w_acc_fall;
   logic                w_pulse;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .clr (clr),
      .d   (bus.raw_in),
      .q   (w_s)
   );

   // A one-edge window means a differing sample is accepted immediately,
   // without ever visiting a CHECK_* state.
   generate
      if (DEBOUNCE_CYCLES == 1) begin : g_fast_accept
         assign w_fast = 1'b1;
      end else begin : g_windowed_accept
         assign w_fast = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= STABLE_LO;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_rise  = 1'b0;
      w_acc_fall  = 1'b0;
      case (r_state)
         STABLE_LO: begin
            if (w_s) begin
               if (w_fast) begin
                  w_state_nxt = STABLE_HI;
                  w_acc_rise  = 1'b1;
               end else begin
                  w_state_nxt = CHECK_HI;
                  w_cnt_nxt   = c_cnt_one;
               end
            end
         end
         CHECK_HI: begin
            // Any return to the old level discards the partial window.
            if (!w_s) begin
               w_state_nxt = STABLE_LO;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = STABLE_HI;
               w_cnt_nxt   = '0;
               w_acc_rise  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!w_s) begin
               if (w_fast) begin
                  w_state_nxt = STABLE_LO;
                  w_acc_fall  = 1'b1;
               end else begin
                  w_state_nxt = CHECK_LO;
                  w_cnt_nxt   = c_cnt_one;
               end
            end
         end
         CHECK_LO: begin
            if (w_s) begin
               w_state_nxt = STABLE_HI;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = STABLE_LO;
               w_cnt_nxt   = '0;
               w_acc_fall  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Only the mode present at the accepting edge decides the pulse.
   always_comb begin
      w_pulse = 1'b0;
      case (bus.mode)
         MODE_RISE: w_pulse = w_acc_rise;
         MODE_FALL: w_pulse = w_acc_fall;
         MODE_BOTH: w_pulse = w_acc_rise | w_acc_fall;
         MODE_NONE: ;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_stable <= 1'b0;
         r_bit    <= 1'b0;
         r_pcount <= '0;
      end else begin
         r_bit <= w_pulse;
         if (w_acc_rise) begin
            r_stable <= 1'b1;
         end else if (w_acc_fall) begin
            r_stable <= 1'b0;
         end
         if (w_pulse) begin
            r_pcount <= r_pcount + 1'b1;
         end
      end
   end

   assign bus.bit_out      = r_bit;
   assign bus.stable_level = r_stable;
   assign bus.pulse_count  = r_pcount;

endmodule : toggle_enable_gen

`default_nettype wire

// File: tb/tb_toggle_enable_gen.sv
//============================================================================
// Module : tb_toggle_enable_gen
// Desc   : Scoreboard bench for toggle_enable_gen with a downstream toggle.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_toggle_enable_gen;
   import toggle_pkg::*;

   localparam int LAT = 6;

   typedef struct {
      int         cyc;
      logic [7:0] cnt;
      logic       lvl;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       q[$];
   logic [7:0] exp_pcount = 8'd0;
   logic       tq;
   logic       tq_prev = 1'b0;
   logic       tq0;
   int         n_tog = 0;

   toggle_enable_gen_if #(.PCOUNT_W(8)) bus ();

   toggle_enable_gen #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .PCOUNT_W        (8)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream toggle stage driven by the enable.
   always @(posedge clk or posedge clr) begin
      if (clr) tq <= 1'b0;
      else if (bus.bit_out) tq <= ~tq;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at the negedge where raw_in is changed; that edge's next
   // posedge is edge 1 of the latency count.
   task automatic push(input logic lvl);
      exp_t e;
      exp_pcount = exp_pcount + 8'd1;
      e.cyc = cyc + LAT;
      e.cnt = exp_pcount;
      e.lvl = lvl;
      q.push_back(e);
   endtask

   // Monitor: compares each presented pulse with the oldest expectation.
   always @(negedge clk) begin
      if (tq !== tq_prev) n_tog++;
      tq_prev = tq;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         chk("missing_pulse_cycle", 0, q[0].cyc);
         void'(q.pop_front());
      end
      if (bus.bit_out === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            chk("pulse_cycle", cyc, q[0].cyc);
            chk("pulse_count", int'(bus.pulse_count), int'(q[0].cnt));
            chk("pulse_level", int'(bus.stable_level), int'(q[0].lvl));
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr         = 1'b1;
      bus.raw_in  = 1'b0;
      bus.mode    = MODE_RISE;
      #1;
      chk("rst_stable", int'(bus.stable_level), 0);
      chk("rst_bit", int'(bus.bit_out), 0);
      chk("rst_count", int'(bus.pulse_count), 0);
      idle(2);
      clr = 1'b0;

      // Clean rise, then an unqualified fall.
      idle(1);
      bus.raw_in = 1'b1; push(1'b1);
      idle(20);
      chk("rise_level", int'(bus.stable_level), 1);
      chk("rise_count", int'(bus.pulse_count), 1);
      bus.raw_in = 1'b0;
      idle(20);
      chk("fall_level", int'(bus.stable_level), 0);

      // Bounce: three edges high, one low, then steady high.
      bus.raw_in = 1'b1; idle(3);
      bus.raw_in = 1'b0; idle(1);
      bus.raw_in = 1'b1; push(1'b1);
      idle(20);
      bus.raw_in = 1'b0; idle(20);
      chk("bounce_count", int'(bus.pulse_count), 2);

      // Both edges, then no edges.
      bus.mode = MODE_BOTH;
      bus.raw_in = 1'b1; push(1'b1); idle(20);
      bus.raw_in = 1'b0; push(1'b0); idle(20);
      chk("both_count", int'(bus.pulse_count), 4);
      bus.mode = MODE_NONE;
      bus.raw_in = 1'b1; idle(20);
      chk("none_level_hi", int'(bus.stable_level), 1);
      bus.raw_in = 1'b0; idle(20);
      chk("none_level_lo", int'(bus.stable_level), 0);
      chk("none_count", int'(bus.pulse_count), 4);

      // Mode changed mid-check: only the accepting edge's mode counts.
      bus.raw_in = 1'b1; push(1'b1); idle(2);
      bus.mode = MODE_RISE; idle(18);
      bus.raw_in = 1'b0; idle(20);
      bus.raw_in = 1'b1; idle(3);
      bus.mode = MODE_NONE; idle(17);
      chk("modechg_level", int'(bus.stable_level), 1);
      chk("modechg_count", int'(bus.pulse_count), 5);
      bus.raw_in = 1'b0; idle(20);

      // clr mid-check with raw_in held high.
      bus.mode = MODE_RISE;
      bus.raw_in = 1'b1; idle(3);
      clr = 1'b1;
      #1;
      chk("clr_stable", int'(bus.stable_level), 0);
      chk("clr_bit", int'(bus.bit_out), 0);
      chk("clr_count", int'(bus.pulse_count), 0);
      exp_pcount = 8'd0;
      idle(1);
      clr = 1'b0; push(1'b1);
      idle(20);
      chk("clr_after_count", int'(bus.pulse_count), 1);
      bus.raw_in = 1'b0; idle(20);

      // 256 pulses: counter wraps, toggle returns to its start value.
      clr = 1'b1; idle(1);
      clr = 1'b0; exp_pcount = 8'd0;
      idle(2);
      tq0   = tq;
      n_tog = 0;
      for (int i = 0; i < 256; i++) begin
         bus.raw_in = 1'b1; push(1'b1); idle(10);
         bus.raw_in = 1'b0; idle(10);
      end
      idle(4);
      chk("wrap_count", int'(bus.pulse_count), 0);
      chk("wrap_toggle", int'(tq), int'(tq0));
      chk("wrap_toggles", n_tog, 256);

      idle(10);
      chk("sb_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_toggle_enable_gen

`default_nettype wire
